decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_pkg.sv | 32 +++
 rtl/decode_queue_ptr_ctrl.sv | 87 ++++++++
 rtl/decode_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg -- types shared by ID, the decode queue and RENAME.
//
// Contents:
//   ALU_CTRL_W    width of the ALU control field
//   REG_W         width of register specifiers and shift amounts
//   WORD_W        width of instruction word, PC and immediate
//   decoded_op_t  one decoded instruction (126 bits)
//   DECODED_OP_W  packed width of decoded_op_t
package decode_queue_pkg;

  localparam int ALU_CTRL_W = 6;
  localparam int REG_W      = 5;
  localparam int WORD_W     = 32;

  typedef struct packed {
    logic [WORD_W-1:0]     instr;
    logic [WORD_W-1:0]     pc;
    logic [WORD_W-1:0]     immediate;
    logic                  has_immediate;
    logic [REG_W-1:0]      reg_a;
    logic [REG_W-1:0]      reg_b;
    logic [REG_W-1:0]      write_reg;
    logic                  reg_write;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_W-1:0]      shift_amount;
  } decoded_op_t;

  localparam int DECODED_OP_W = $bits(decoded_op_t);

endpackage

// File: rtl/decode_queue_ptr_ctrl.sv
// dq_ptr_ctrl -- pointer, occupancy and overflow bookkeeping for decode_queue.
//
// Ports:
//   CLK, RESET   clock (rising edge), asynchronous active-low reset
//   push_req     producer offers an entry this cycle
//   pop_req      consumer takes the head entry this cycle
//   flush        discard every entry (pointers and count return to 0)
//   wr_ptr       slot the next accepted push writes
//   rd_ptr       slot holding the head entry
//   count        occupancy, 0..DEPTH
//   full, empty  count==DEPTH / count==0
//   overflow     sticky: a push was dropped because the queue was full
//   push_ok      push accepted this cycle (storage write enable)
module dq_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             push_ok
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             pop_ok;
  logic             push_drop;

  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop_ok    = pop_req & ~empty & ~flush;
  assign push_ok   = push_req & ~flush & (~full | pop_ok);
  assign push_drop = push_req & ~flush & full & ~pop_ok;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg | push_drop;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (push_ok) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + (PTR_W+1)'(1);
        2'b01:   count_next = count_reg - (PTR_W+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign wr_ptr   = wr_ptr_reg;
  assign rd_ptr   = rd_ptr_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/decode_queue.sv
// decode_queue -- in-order queue of decoded instructions between ID and RENAME.
//
// Ports:
//   CLK, RESET                  clock (rising edge), asynchronous active-low reset
//   Push_FIFO + *_IN fields     decoded instruction offered by ID
//   FLUSH_IN                    drop every queued entry
//   Pop_IN                      RENAME consumes the head entry
//   Instr1_Valid_OUT + *_OUT    head entry (all data zero when not valid)
//   Full_OUT, Count_OUT         occupancy status, ID freezes on Full_OUT
//   Overflow_OUT                sticky flag: a push was dropped while full
//
// Configuration macro DQ_BYPASS_EN: when defined, a push into an empty queue
// is visible on the outputs in the same cycle; if it is also popped that
// cycle it is consumed without ever being stored.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    Push_FIFO,
  input  logic [WORD_W-1:0]       Instr1_IN,
  input  logic [WORD_W-1:0]       Instr1_PC_IN,
  input  logic [WORD_W-1:0]       Immediate_IN,
  input  logic                    HasImmediate_IN,
  input  logic                    RegWrite1_IN,
  input  logic                    MemRead1_IN,
  input  logic                    MemWrite1_IN,
  input  logic [REG_W-1:0]        ReadRegisterA1_IN,
  input  logic [REG_W-1:0]        ReadRegisterB1_IN,
  input  logic [REG_W-1:0]        WriteRegister1_IN,
  input  logic [REG_W-1:0]        ShiftAmount1_IN,
  input  logic [ALU_CTRL_W-1:0]   ALU_Control1_IN,
  input  logic                    FLUSH_IN,
  input  logic                    Pop_IN,
  output logic                    Instr1_Valid_OUT,
  output logic [WORD_W-1:0]       Instr1_OUT,
  output logic [WORD_W-1:0]       Instr1_PC_OUT,
  output logic [WORD_W-1:0]       Immediate_OUT,
  output logic                    HasImmediate_OUT,
  output logic                    RegWrite1_OUT,
  output logic                    MemRead1_OUT,
  output logic                    MemWrite1_OUT,
  output logic [REG_W-1:0]        ReadRegisterA1_OUT,
  output logic [REG_W-1:0]        ReadRegisterB1_OUT,
  output logic [REG_W-1:0]        WriteRegister1_OUT,
  output logic [REG_W-1:0]        ShiftAmount1_OUT,
  output logic [ALU_CTRL_W-1:0]   ALU_Control1_OUT,
  output logic                    Full_OUT,
  output logic [$clog2(DEPTH):0]  Count_OUT,
  output logic                    Overflow_OUT
);

  localparam int PTR_W = $clog2(DEPTH);

  decoded_op_t      in_op;
  decoded_op_t      head_op;
  decoded_op_t      out_op;
  decoded_op_t      mem_reg [DEPTH];
  logic             out_valid;
  logic             bypass_active;
  logic             bypass_take;
  logic             push_req;
  logic             push_ok;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow;

  always_comb begin
    in_op               = '0;
    in_op.instr         = Instr1_IN;
    in_op.pc            = Instr1_PC_IN;
    in_op.immediate     = Immediate_IN;
    in_op.has_immediate = HasImmediate_IN;
    in_op.reg_a         = ReadRegisterA1_IN;
    in_op.reg_b         = ReadRegisterB1_IN;
    in_op.write_reg     = WriteRegister1_IN;
    in_op.reg_write     = RegWrite1_IN;
    in_op.alu_control   = ALU_Control1_IN;
    in_op.mem_read      = MemRead1_IN;
    in_op.mem_write     = MemWrite1_IN;
    in_op.shift_amount  = ShiftAmount1_IN;
  end

`ifdef DQ_BYPASS_EN
  // RESET is included so the outputs stay zero while reset is held, even
  // if ID keeps Push_FIFO high.
  assign bypass_active = RESET & empty & Push_FIFO & ~FLUSH_IN;
`else
  assign bypass_active = 1'b0;
`endif

  // A bypassed entry that is popped in the same cycle never enters storage.
  assign bypass_take = bypass_active & Pop_IN;
  assign push_req    = Push_FIFO & ~bypass_take;

  dq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .CLK      (CLK),
    .RESET    (RESET),
    .push_req (push_req),
    .pop_req  (Pop_IN),
    .flush    (FLUSH_IN),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .push_ok  (push_ok)
  );

  // Storage is not reset; occupancy alone decides what is valid. The write
  // is held off while reset is asserted so an interrupted push leaves no trace.
  always_ff @(posedge CLK) begin
    if (push_ok && RESET) begin
      mem_reg[wr_ptr] <= in_op;
    end
  end

  assign head_op = mem_reg[rd_ptr];

  always_comb begin
    out_valid = ~empty;
    out_op    = head_op;
    if (bypass_active) begin
      out_valid = 1'b1;
      out_op    = in_op;
    end
    if (!out_valid) begin
      out_op = '0;
    end
  end

  assign Instr1_Valid_OUT   = out_valid;
  assign Instr1_OUT         = out_op.instr;
  assign Instr1_PC_OUT      = out_op.pc;
  assign Immediate_OUT      = out_op.immediate;
  assign HasImmediate_OUT   = out_op.has_immediate;
  assign RegWrite1_OUT      = out_op.reg_write;
  assign MemRead1_OUT       = out_op.mem_read;
  assign MemWrite1_OUT      = out_op.mem_write;
  assign ReadRegisterA1_OUT = out_op.reg_a;
  assign ReadRegisterB1_OUT = out_op.reg_b;
  assign WriteRegister1_OUT = out_op.write_reg;
  assign ShiftAmount1_OUT   = out_op.shift_amount;
  assign ALU_Control1_OUT   = out_op.alu_control;
  assign Full_OUT           = full;
  assign Count_OUT          = count;
  assign Overflow_OUT       = overflow;

endmodule
